bcd_seq_adder_display: RTL and testbench

- Parametrised multi-digit BCD adder/subtractor. It processes one decimal digit per clock, least-significant digit first, with a start/busy/done handshake.
- Drives one active-low seven-segment code per result digit, plus one carry/sign display.
- Successor to the single-digit combinational BCD adder/display. Adds width generalisation, a subtract mode, input validity checking and registered, flicker-free outputs.

---
 rtl/bcd_seq_adder_display_if.sv | 28 ++
 rtl/bcd_seq_adder_display.sv | 179 +++++++++++++++++
 tb/tb_bcd_seq_adder_display.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_adder_display_if.sv
// Handshake and data bundle for the sequential BCD adder/subtractor with display.
// The master drives the request, and the slave returns the result and segment codes.
interface bcd_seq_adder_display_if #(
    parameter int DIGITS = 4
);
    logic                     start;
    logic                     mode;
    logic                     cin;
    logic [4*DIGITS-1:0]      a_bcd;
    logic [4*DIGITS-1:0]      b_bcd;
    logic                     busy;
    logic                     done;
    logic [4*DIGITS-1:0]      sum_bcd;
    logic                     cout;
    logic                     neg;
    logic                     err;
    logic [7*(DIGITS+1)-1:0]  seg;

    modport master (
        output start, mode, cin, a_bcd, b_bcd,
        input  busy, done, sum_bcd, cout, neg, err, seg
    );

    modport slave (
        input  start, mode, cin, a_bcd, b_bcd,
        output busy, done, sum_bcd, cout, neg, err, seg
    );
endinterface

// File: rtl/bcd_seq_adder_display.sv
// Multi-digit BCD adder/subtractor that processes one digit per clock, least-significant digit first.
// Results and active-low seven-segment codes are registered, and they change only when an operation completes.
module bcd_seq_adder_display #(
    parameter int DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    bcd_seq_adder_display_if.slave     bus
);
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;
    localparam int SW = 7 * (DIGITS + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            mode_q, mode_d;
    logic            c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic [SW-1:0]   seg_q, seg_d;

    logic [3:0]          a_arr [DIGITS];
    logic [3:0]          b_arr [DIGITS];
    logic [DIGITS-1:0]   a_bad, b_bad;
    logic [W-1:0]        work_step;
    logic [7*DIGITS-1:0] dig_seg;
    logic [3:0]          b_eff;
    logic [4:0]          t_sum;
    logic [3:0]          dig_sum;
    logic                c_nx;
    logic [6:0]          sign_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Per-digit views: input validity, latched operand digits, next working value and its segment code
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign a_bad[gi]            = (bus.a_bcd[4*gi +: 4] > 4'd9);
            assign b_bad[gi]            = (bus.b_bcd[4*gi +: 4] > 4'd9);
            assign a_arr[gi]            = a_q[4*gi +: 4];
            assign b_arr[gi]            = b_q[4*gi +: 4];
            assign work_step[4*gi +: 4] = (k_q == KW'(gi)) ? dig_sum : work_q[4*gi +: 4];
            assign dig_seg[7*gi +: 7]   = seg7(work_step[4*gi +: 4]);
        end
    endgenerate

    // One decimal digit slice. Subtraction uses the nines' complement of B with carry-in forced to 1.
    always_comb begin
        b_eff = mode_q ? (4'd9 - b_arr[k_q]) : b_arr[k_q];
        t_sum = {1'b0, a_arr[k_q]} + {1'b0, b_eff} + {4'b0000, c_q};
        if (t_sum >= 5'd10) begin
            dig_sum = 4'(t_sum - 5'd10);
            c_nx    = 1'b1;
        end else begin
            dig_sum = t_sum[3:0];
            c_nx    = 1'b0;
        end
        if (mode_q) begin
            sign_seg = c_nx ? SEG_BLANK : SEG_MINUS;
        end else begin
            sign_seg = c_nx ? SEG_ONE : SEG_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        c_d     = c_q;
        k_d     = k_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        err_d   = err_q;
        seg_d   = seg_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d    = bus.a_bcd;
                    b_d    = bus.b_bcd;
                    mode_d = bus.mode;
                    c_d    = bus.mode | bus.cin;
                    k_d    = '0;
                    work_d = '0;
                    if ((|a_bad) || (|b_bad)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        neg_d   = 1'b0;
                        seg_d   = {{DIGITS{SEG_BLANK}}, SEG_E};
                    end else begin
                        state_d = S_RUN;
                        err_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                work_d = work_step;
                c_d    = c_nx;
                k_d    = k_q + 1'b1;
                if (k_q == KW'(DIGITS - 1)) begin
                    state_d = S_DONE;
                    sum_d   = work_step;
                    cout_d  = ~mode_q & c_nx;
                    neg_d   = mode_q & ~c_nx;
                    seg_d   = {sign_seg, dig_seg};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            c_q     <= 1'b0;
            k_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            k_q     <= k_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.sum_bcd = sum_q;
    assign bus.cout    = cout_q;
    assign bus.neg     = neg_q;
    assign bus.err     = err_q;
    assign bus.seg     = seg_q;
endmodule

// File: tb/tb_bcd_seq_adder_display.sv
// Bench for bcd_seq_adder_display (DIGITS=4): directed table, control corner cases,
// and random operations checked against an integer-arithmetic reference.
module tb_bcd_seq_adder_display;
    localparam int D  = 4;
    localparam int W  = 4 * D;
    localparam int SW = 7 * (D + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_seq_adder_display_if #(.DIGITS(D)) bus ();

    bcd_seq_adder_display #(.DIGITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ng;
        logic         er;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    logic [6:0] seg_tab [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < D; i++) begin
            r += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: whole-number arithmetic modulo 10^D
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ng, output logic er);
        int modv = 1;
        int r;
        er = 1'b0;
        for (int i = 0; i < D; i++) begin
            modv *= 10;
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) er = 1'b1;
        end
        s = '0; co = 1'b0; ng = 1'b0;
        if (!er) begin
            if (!m) begin
                r  = bcd2int(a) + bcd2int(b) + int'(ci);
                co = (r >= modv);
                s  = int2bcd(r % modv);
            end else begin
                r  = bcd2int(a) - bcd2int(b);
                ng = (r < 0);
                s  = int2bcd((r + modv) % modv);
            end
        end
    endtask

    function automatic logic [SW-1:0] exp_seg(input logic [W-1:0] s, input logic m, input logic co,
                                              input logic ng, input logic er);
        logic [SW-1:0] r = '1;
        if (er) begin
            r[6:0] = 7'b0000110;
        end else begin
            for (int i = 0; i < D; i++) r[7*i +: 7] = seg_tab[s[4*i +: 4]];
            if (!m && co) r[7*D +: 7] = 7'b1111001;
            if (m && ng)  r[7*D +: 7] = 7'b0111111;
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input logic ci, input logic [W-1:0] es,
                          input logic eco, input logic eng, input logic eer);
        int lat;
        @(negedge clk);
        bus.a_bcd = a; bus.b_bcd = b; bus.mode = m; bus.cin = ci; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_bcd = W'($urandom); bus.b_bcd = W'($urandom);
        bus.mode = 1'($urandom); bus.cin = 1'($urandom);
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("op %s: a=%h b=%h mode=%0d cin=%0d -> sum=%h cout=%0d neg=%0d err=%0d latency=%0d",
                 tag, a, b, m, ci, bus.sum_bcd, bus.cout, bus.neg, bus.err, lat);
        check({tag, " latency"}, 64'(lat), eer ? 64'd1 : 64'(D + 1));
        check({tag, " sum"}, 64'(bus.sum_bcd), 64'(es));
        check({tag, " cout"}, 64'(bus.cout), 64'(eco));
        check({tag, " neg"}, 64'(bus.neg), 64'(eng));
        check({tag, " err"}, 64'(bus.err), 64'(eer));
        check({tag, " seg"}, 64'(bus.seg), 64'(exp_seg(es, m, eco, eng, eer)));
        @(negedge clk);
        check({tag, " done pulse"}, 64'(bus.done), 64'd0);
        check({tag, " busy after"}, 64'(bus.busy), 64'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int ndone;
        logic [W-1:0] ra, rb, es;
        logic rm, rci, eco, eng, eer;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        vecs[0] = '{16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0009, 16'h0009, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'h5000, 16'h5000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0; bus.mode = 1'b0; bus.cin = 1'b0; bus.a_bcd = '0; bus.b_bcd = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset sum", 64'(bus.sum_bcd), 64'd0);
        check("reset flags", 64'({bus.cout, bus.neg, bus.err}), 64'd0);
        check("reset seg", 64'(bus.seg), 64'({SW{1'b1}}));
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].ci,
                   vecs[i].s, vecs[i].co, vecs[i].ng, vecs[i].er);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        bus.a_bcd = 16'h1234; bus.b_bcd = 16'h4321; bus.mode = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a_bcd = 16'h9999; bus.b_bcd = 16'h9999; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        $display("op start-during-run: sum=%h dones=%0d", bus.sum_bcd, ndone);
        check("ignored start dones", 64'(ndone), 64'd1);
        check("ignored start sum", 64'(bus.sum_bcd), 64'h5555);

        // asynchronous reset in the middle of RUN
        bus.a_bcd = 16'h1111; bus.b_bcd = 16'h2222; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("op reset-mid-run: busy=%0d sum=%h seg=%h", bus.busy, bus.sum_bcd, bus.seg);
        check("midrun reset busy", 64'(bus.busy), 64'd0);
        check("midrun reset done", 64'(bus.done), 64'd0);
        check("midrun reset sum", 64'(bus.sum_bcd), 64'd0);
        check("midrun reset flags", 64'({bus.cout, bus.neg, bus.err}), 64'd0);
        check("midrun reset seg", 64'(bus.seg), 64'({SW{1'b1}}));
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrun reset no done", 64'(ndone), 64'd0);
        run_op("after-reset", 16'h2468, 16'h1357, 1'b0, 1'b1, 16'h3826, 1'b0, 1'b0, 1'b0);

        // random operations against the integer reference
        for (int n = 0; n < 30; n++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                int j = $urandom_range(0, D - 1);
                if ($urandom_range(0, 1) == 0) ra[4*j +: 4] = 4'($urandom_range(10, 15));
                else                           rb[4*j +: 4] = 4'($urandom_range(10, 15));
            end
            rm  = 1'($urandom);
            rci = 1'($urandom);
            model(ra, rb, rm, rci, es, eco, eng, eer);
            run_op($sformatf("rand%0d", n), ra, rb, rm, rci, es, eco, eng, eer);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
